static_eval_bank: RTL and testbench

- Parametrised, clocked successor to the single-channel `always_comb` static-variable test.
- Holds N independent channels. Each channel computes two scaled results from its input and keeps a persistent per-channel evaluation counter: the count of accepted transactions whose input changed.
- Used as a simulator regression block covering static state, multiplication width truncation, counter wrap/saturation, valid/ready handshakes and async reset.

---
 rtl/static_eval_bank.sv | 152 +++++++++++++++
 tb/tb_static_eval_bank.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/static_eval_bank.sv
// static_eval_bank: N-channel scaled-result bank with persistent per-channel
// evaluation counters behind a valid/ready handshake (IDLE -> COMPUTE -> HOLD).
// Optional feature: define STATIC_EVAL_TRACE_EN to add a free-running cycle
// counter and a per-channel $display trace on every output handshake.
module static_eval_bank #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8,
  parameter int MUL_A     = 2,
  parameter int MUL_Y     = 2,
  parameter int MUL_B     = 3,
  parameter int SATURATE  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_counts,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*WIDTH-1:0]     in_x,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*WIDTH-1:0]     out_a,
  output logic [CHANNELS*WIDTH-1:0]     out_b,
  output logic [CHANNELS*CNT_WIDTH-1:0] out_u,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

  // Multipliers sized to WIDTH so every product truncates to WIDTH bits.
  localparam logic [WIDTH-1:0]     MA   = WIDTH'(MUL_A);
  localparam logic [WIDTH-1:0]     MY   = WIDTH'(MUL_Y);
  localparam logic [WIDTH-1:0]     MB   = WIDTH'(MUL_B);
  localparam logic [CNT_WIDTH-1:0] ONES = '1;

  state_t state, next_state;

  logic [WIDTH-1:0]     x_q    [CHANNELS];
  logic [WIDTH-1:0]     last_x [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt    [CHANNELS];
  logic [CHANNELS-1:0]  seen;

  logic [WIDTH-1:0]     a_c    [CHANNELS];
  logic [WIDTH-1:0]     y_c    [CHANNELS];
  logic [WIDTH-1:0]     b_c    [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_c  [CHANNELS];
  logic [CHANNELS-1:0]  inc_c;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: one transaction in flight, single-cycle COMPUTE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = COMPUTE;
      COMPUTE: next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // Per-channel results and counter update; a concurrent clear is applied
  // before the increment decision so the channel counts as first-seen.
  // NOTE: every always_comb output gets a value on every path (assigned
  // unconditionally here) so no latch is inferred.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      logic [CNT_WIDTH-1:0] base;
      logic                 seen_eff;
      a_c[i]   = x_q[i] * MA;
      y_c[i]   = x_q[i] * MY;
      b_c[i]   = y_c[i] * MB;
      base     = clr_counts ? '0 : cnt[i];
      seen_eff = clr_counts ? 1'b0 : seen[i];
      inc_c[i] = !seen_eff || (x_q[i] != last_x[i]);
      cnt_c[i] = base;
      if (inc_c[i]) begin
        if (base == ONES) cnt_c[i] = (SATURATE != 0) ? ONES : '0;
        else              cnt_c[i] = base + CNT_WIDTH'(1);
      end
    end
  end

  // Datapath registers: input capture, result registers, counters and flags.
  // NOTE: the per-channel arrays are plain flops rather than a RAM, so they
  // take the async reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a <= '0;
      out_b <= '0;
      out_u <= '0;
      seen  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        x_q[i]    <= '0;
        last_x[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      if (state == IDLE && in_valid) begin
        for (int i = 0; i < CHANNELS; i++) x_q[i] <= in_x[i*WIDTH +: WIDTH];
      end
      if (state == COMPUTE) begin
        for (int i = 0; i < CHANNELS; i++) begin
          out_a[i*WIDTH +: WIDTH]         <= a_c[i];
          out_b[i*WIDTH +: WIDTH]         <= b_c[i];
          out_u[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_c[i];
          cnt[i]                          <= cnt_c[i];
          if (inc_c[i]) last_x[i] <= x_q[i];
        end
        seen <= inc_c | (clr_counts ? '0 : seen);
      end else if (clr_counts) begin
        seen <= '0;
        for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
      end
    end
  end

`ifdef STATIC_EVAL_TRACE_EN
  logic [31:0] cycle_q;

  // Free-running cycle counter used to timestamp trace lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_q <= '0;
    else     cycle_q <= cycle_q + 32'd1;
  end

  // One trace line per channel on each output handshake.
  always_ff @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      for (int i = 0; i < CHANNELS; i++) begin
        $display("[%3d] ch%0d x: %3d a: %3d b: %3d u: %3d", cycle_q, i, x_q[i],
                 out_a[i*WIDTH +: WIDTH], out_b[i*WIDTH +: WIDTH],
                 out_u[i*CNT_WIDTH +: CNT_WIDTH]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_static_eval_bank.sv
// tb_static_eval_bank: three instances (default 32-bit/8-bit counter, and
// 8-bit data with 2-bit counters wrapping and saturating) driven in lockstep
// and compared against an arithmetic reference model.
module tb_static_eval_bank;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst, clr_counts, in_valid, out_ready;
  always #5 clk = ~clk;

  logic [127:0] x0;
  logic [31:0]  x1;
  wire  [2:0]   ir, ov, bz;
  wire  [127:0] a0, b0;
  wire  [31:0]  u0, a1, b1, a2, b2;
  wire  [7:0]   u1, u2;

  static_eval_bank dut0 (
    .clk(clk), .rst(rst), .clr_counts(clr_counts), .in_valid(in_valid), .in_ready(ir[0]),
    .in_x(x0), .out_valid(ov[0]), .out_ready(out_ready), .out_a(a0), .out_b(b0),
    .out_u(u0), .busy(bz[0]));
  static_eval_bank #(.WIDTH(8), .CNT_WIDTH(2), .SATURATE(0)) dut1 (
    .clk(clk), .rst(rst), .clr_counts(clr_counts), .in_valid(in_valid), .in_ready(ir[1]),
    .in_x(x1), .out_valid(ov[1]), .out_ready(out_ready), .out_a(a1), .out_b(b1),
    .out_u(u1), .busy(bz[1]));
  static_eval_bank #(.WIDTH(8), .CNT_WIDTH(2), .SATURATE(1)) dut2 (
    .clk(clk), .rst(rst), .clr_counts(clr_counts), .in_valid(in_valid), .in_ready(ir[2]),
    .in_x(x1), .out_valid(ov[2]), .out_ready(out_ready), .out_a(a2), .out_b(b2),
    .out_u(u2), .busy(bz[2]));

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int W[3]   = '{32, 8, 8};
  int CW[3]  = '{8, 2, 2};
  int SAT[3] = '{0, 0, 1};
  longint m_last[3][CH], m_cnt[3][CH], e_a[3][CH], e_b[3][CH], e_u[3][CH];
  bit     m_seen[3][CH];
  longint xv[CH];

  task automatic check(input string tag, input longint o, input longint e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, o, e);
    end
  endtask

  function automatic longint obs(input int d, input int k, input int ch);
    case (d)
      0: case (k) 0: return longint'(a0[ch*32 +: 32]); 1: return longint'(b0[ch*32 +: 32]);
                  default: return longint'(u0[ch*8 +: 8]); endcase
      1: case (k) 0: return longint'(a1[ch*8 +: 8]); 1: return longint'(b1[ch*8 +: 8]);
                  default: return longint'(u1[ch*2 +: 2]); endcase
      default: case (k) 0: return longint'(a2[ch*8 +: 8]); 1: return longint'(b2[ch*8 +: 8]);
                  default: return longint'(u2[ch*2 +: 2]); endcase
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < CH; c++) begin m_cnt[d][c] = 0; m_seen[d][c] = 0; end
  endtask

  task automatic model_reset();
    model_clear();
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < CH; c++) begin
        m_last[d][c] = 0; e_a[d][c] = 0; e_b[d][c] = 0; e_u[d][c] = 0;
      end
  endtask

  task automatic model_compute(input bit clr);
    if (clr) model_clear();
    for (int d = 0; d < 3; d++) begin
      longint mask = (64'sd1 <<< W[d]) - 1;
      longint cmax = (64'sd1 <<< CW[d]) - 1;
      for (int c = 0; c < CH; c++) begin
        longint x = xv[c] & mask;
        longint y = (x * 2) & mask;
        e_a[d][c] = (x * 2) & mask;
        e_b[d][c] = (y * 3) & mask;
        if (!m_seen[d][c] || x != m_last[d][c]) begin
          m_seen[d][c] = 1;
          m_last[d][c] = x;
          if (m_cnt[d][c] == cmax) m_cnt[d][c] = (SAT[d] != 0) ? cmax : 0;
          else                     m_cnt[d][c] = m_cnt[d][c] + 1;
        end
        e_u[d][c] = m_cnt[d][c];
      end
    end
  endtask

  task automatic drive_x(input longint v[CH]);
    for (int c = 0; c < CH; c++) begin
      x0[c*32 +: 32] = v[c][31:0];
      x1[c*8 +: 8]   = v[c][7:0];
    end
  endtask

  task automatic check_ctrl(input string tag, input bit e_ir, input bit e_ov, input bit e_bz);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s d%0d in_ready", tag, d), longint'(ir[d]), longint'(e_ir));
      check($sformatf("%s d%0d out_valid", tag, d), longint'(ov[d]), longint'(e_ov));
      check($sformatf("%s d%0d busy", tag, d), longint'(bz[d]), longint'(e_bz));
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < CH; c++) begin
        check($sformatf("%s d%0d ch%0d a", tag, d, c), obs(d, 0, c), e_a[d][c]);
        check($sformatf("%s d%0d ch%0d b", tag, d, c), obs(d, 1, c), e_b[d][c]);
        check($sformatf("%s d%0d ch%0d u", tag, d, c), obs(d, 2, c), e_u[d][c]);
      end
  endtask

  // One full transaction, starting and ending #1 after a rising edge in IDLE.
  task automatic txn(input string tag, input bit clr_c, input int hold);
    longint junk[CH];
    check_ctrl({tag, " idle"}, 1, 0, 0);
    drive_x(xv);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check_ctrl({tag, " compute"}, 0, 0, 1);
    clr_counts = clr_c;
    @(posedge clk); #1;
    clr_counts = 0;
    model_compute(clr_c);
    check_ctrl({tag, " hold"}, 0, 1, 1);
    check_outputs({tag, " hold"});
    if (hold > 0) begin
      for (int c = 0; c < CH; c++) junk[c] = ~xv[c];
      drive_x(junk);
      in_valid = 1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check_ctrl($sformatf("%s stall%0d", tag, h), 0, 1, 1);
        check_outputs($sformatf("%s stall%0d", tag, h));
      end
      in_valid = 0;
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check_ctrl({tag, " done"}, 1, 0, 0);
    check_outputs({tag, " retained"});
  endtask

  int seq_x[4]  = '{1, 2, 2, 5};
  int seq_a[4]  = '{2, 4, 4, 10};
  int seq_b[4]  = '{6, 12, 12, 30};
  int seq_u[4]  = '{1, 2, 2, 3};
  int wrap_u[5] = '{1, 2, 3, 0, 1};
  int sat_u[5]  = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1; clr_counts = 0; in_valid = 0; out_ready = 0;
    for (int c = 0; c < CH; c++) xv[c] = 0;
    drive_x(xv);
    model_reset();
    #12;
    check_ctrl("reset", 1, 0, 0);
    check_outputs("reset");
    rst = 0;
    @(posedge clk); #1;

    // All-zero inputs: every channel first-seen.
    txn("zeros", 0, 0);
    check("zeros ch0 u", longint'(u0[7:0]), 1);

    // Clear in IDLE: state and outputs untouched.
    clr_counts = 1;
    @(posedge clk); #1;
    clr_counts = 0;
    model_clear();
    check_ctrl("clr idle", 1, 0, 0);
    check_outputs("clr idle");

    // ch0 sequence 1,2,2,5; ch1 = 200 exercises 8-bit truncation.
    for (int k = 0; k < 4; k++) begin
      xv[0] = seq_x[k]; xv[1] = 200; xv[2] = 7; xv[3] = 64'hFFFF_FFFF;
      txn($sformatf("seq%0d", k), 0, 0);
      check($sformatf("seq%0d ch0 a", k), longint'(a0[31:0]), seq_a[k]);
      check($sformatf("seq%0d ch0 b", k), longint'(b0[31:0]), seq_b[k]);
      check($sformatf("seq%0d ch0 u", k), longint'(u0[7:0]), seq_u[k]);
    end
    check("w8 x200 a", longint'(a1[15:8]), 144);
    check("w8 x200 b", longint'(b1[15:8]), 176);
    check("w32 xmax a", longint'(a0[127:96]), 64'hFFFF_FFFE);

    // Five distinct values into 2-bit counters: wrap vs saturate.
    clr_counts = 1;
    @(posedge clk); #1;
    clr_counts = 0;
    model_clear();
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < CH; c++) xv[c] = 10 + k + c;
      txn($sformatf("cnt%0d", k), 0, 0);
      check($sformatf("cnt%0d wrap u", k), longint'(u1[1:0]), wrap_u[k]);
      check($sformatf("cnt%0d sat u", k), longint'(u2[1:0]), sat_u[k]);
    end

    // Backpressure for 5 cycles with a competing in_valid.
    xv[0] = 99;
    txn("hold5", 0, 5);

    // Clear during COMPUTE with unchanged inputs: every channel restarts at 1.
    txn("clrcomp", 1, 0);
    check("clrcomp ch0 u", longint'(u0[7:0]), 1);
    check("clrcomp sat u", longint'(u2[1:0]), 1);

    // Reset in the COMPUTE cycle drops the transaction.
    xv[0] = 1234;
    drive_x(xv);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    rst = 1;
    #1;
    model_reset();
    check_ctrl("midrst", 1, 0, 0);
    check_outputs("midrst");
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    txn("postrst", 0, 0);
    check("postrst ch0 u", longint'(u0[7:0]), 1);

    // Randomized transactions with repeats likely on some channels.
    for (int k = 0; k < 25; k++) begin
      for (int c = 0; c < CH; c++)
        xv[c] = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 3)) : longint'($urandom);
      txn($sformatf("rnd%0d", k), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
